window_max_tracker: RTL and testbench

Parametrised sliding-window peak detector: accepts a stream of unsigned samples, each tagged with a key, and keeps a running sum over the last WINDOW accepted samples. It records the largest window sum seen since reset or clear, together with the key of the sample that completed that window. It sits between the sample source and the result/display logic. It supersedes the fixed 8×2-bit detector, adding configurable width and depth, a valid qualifier, a fill guard, tie-break modes and a synchronous clear.

---
 rtl/window_max_tracker_pkg.sv | 25 ++
 rtl/window_sum.sv | 67 ++++++
 rtl/window_max_tracker.sv | 75 +++++++
 tb/tb_window_max_tracker.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/window_max_tracker_pkg.sv
// Shared constants and width helpers for the sliding-window peak detector.
// The sum width is derived here so the top level and the window sub-module agree.
package window_max_tracker_pkg;

  localparam int TIE_EARLIER    = 0;
  localparam int TIE_LATEST_KEY = 1;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // A full window of all-ones samples needs log2(window) extra bits.
  function automatic int sum_width(input int n_data, input int window);
    return n_data + clog2(window);
  endfunction

endpackage

// File: rtl/window_sum.sv
// Circular sample buffer with a running sum over the last WINDOW accepted samples.
// new_sum/full_next describe the sample on the inputs now; cur_sum/window_full are registered.
module window_sum
  import window_max_tracker_pkg::*;
#(
  parameter  int N_DATA = 2,
  parameter  int WINDOW = 8,
  localparam int SUM_W  = sum_width(N_DATA, WINDOW),
  localparam int PTR_W  = clog2(WINDOW),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [N_DATA-1:0] data,
  output logic [SUM_W-1:0]  new_sum,
  output logic              full_next,
  output logic [SUM_W-1:0]  cur_sum,
  output logic              window_full
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WINDOW);

  logic [N_DATA-1:0] samples [WINDOW];
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [N_DATA-1:0] evicted;

  // Until the buffer has wrapped, the slot under wr_ptr holds stale data and must not be subtracted.
  always_comb begin
    evicted   = (cnt == FULL_CNT) ? samples[wr_ptr] : '0;
    new_sum   = cur_sum + SUM_W'(data) - SUM_W'(evicted);
    full_next = (cnt == FULL_CNT) || (cnt == FULL_CNT - CNT_W'(1));
  end

  // NOTE: the sample memory has no reset; cnt gates every read of it, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (in_valid && !clear) begin
      samples[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      cnt         <= '0;
      cur_sum     <= '0;
      window_full <= 1'b0;
    end else if (clear) begin
      wr_ptr      <= '0;
      cnt         <= '0;
      cur_sum     <= '0;
      window_full <= 1'b0;
    end else if (in_valid) begin
      wr_ptr  <= wr_ptr + PTR_W'(1);
      cur_sum <= new_sum;
      if (cnt != FULL_CNT) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (full_next) begin
        window_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/window_max_tracker.sv
// Sliding-window peak detector: tracks the largest full-window sum and the key of the
// sample that completed it, with a one-cycle max_update pulse on every max write.
module window_max_tracker
  import window_max_tracker_pkg::*;
#(
  parameter  int N_DATA     = 2,
  parameter  int N_KEY      = 16,
  parameter  int WINDOW     = 8,
  parameter  int TIE_LATEST = TIE_EARLIER,
  localparam int SUM_W      = sum_width(N_DATA, WINDOW)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [N_DATA-1:0] data,
  input  logic [N_KEY-1:0]  key,
  input  logic              enable,
  output logic              window_full,
  output logic [SUM_W-1:0]  cur_sum,
  output logic              max_valid,
  output logic [SUM_W-1:0]  max_sum,
  output logic [N_KEY-1:0]  max_key,
  output logic              max_update
);

  logic [SUM_W-1:0] new_sum;
  logic             full_next;
  logic             take;

  window_sum #(
    .N_DATA (N_DATA),
    .WINDOW (WINDOW)
  ) u_window_sum (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_valid    (in_valid),
    .data        (data),
    .new_sum     (new_sum),
    .full_next   (full_next),
    .cur_sum     (cur_sum),
    .window_full (window_full)
  );

  // An invalid max always loses, so the first full window wins even with a zero sum.
  always_comb begin
    take = in_valid && enable && full_next &&
           (!max_valid || (new_sum > max_sum) ||
            ((TIE_LATEST == TIE_LATEST_KEY) && (new_sum == max_sum)));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_valid  <= 1'b0;
      max_sum    <= '0;
      max_key    <= '0;
      max_update <= 1'b0;
    end else if (clear) begin
      max_valid  <= 1'b0;
      max_sum    <= '0;
      max_key    <= '0;
      max_update <= 1'b0;
    end else begin
      max_update <= take;
      if (take) begin
        max_valid <= 1'b1;
        max_sum   <= new_sum;
        max_key   <= key;
      end
    end
  end

endmodule

// File: tb/tb_window_max_tracker.sv
// Randomized and directed bench for window_max_tracker: two instances (default, and
// N_DATA=4/WINDOW=16/TIE_LATEST=1) checked against a history-based reference model.
module tb_window_max_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  data = '0;
  logic [15:0] key = '0;

  logic        a_full, a_mvalid, a_upd;
  logic [4:0]  a_sum, a_max;
  logic [15:0] a_key;
  logic        b_full, b_mvalid, b_upd;
  logic [7:0]  b_sum, b_max;
  logic [15:0] b_key;

  always #5 clk = ~clk;

  window_max_tracker dut_a (
    .clk (clk), .reset (reset), .clear (clear), .in_valid (in_valid),
    .data (data[1:0]), .key (key), .enable (enable),
    .window_full (a_full), .cur_sum (a_sum), .max_valid (a_mvalid),
    .max_sum (a_max), .max_key (a_key), .max_update (a_upd)
  );

  window_max_tracker #(.N_DATA(4), .N_KEY(16), .WINDOW(16), .TIE_LATEST(1)) dut_b (
    .clk (clk), .reset (reset), .clear (clear), .in_valid (in_valid),
    .data (data), .key (key), .enable (enable),
    .window_full (b_full), .cur_sum (b_sum), .max_valid (b_mvalid),
    .max_sum (b_max), .max_key (b_key), .max_update (b_upd)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: full accepted history since clear; the window is its last WIN entries.
  localparam int HMAX = 8192;
  int win  [2] = '{8, 16};
  int mask [2] = '{3, 15};
  int tie  [2] = '{0, 1};
  int hist [2][HMAX];
  int hlen [2];
  int m_valid [2];
  int m_max   [2];
  int m_key   [2];
  int m_upd   [2];

  function automatic int model_sum(input int i);
    int s  = 0;
    int lo = (hlen[i] > win[i]) ? hlen[i] - win[i] : 0;
    for (int k = lo; k < hlen[i]; k++) s += hist[i][k];
    return s;
  endfunction

  task automatic model_clear(input int i);
    hlen[i] = 0; m_valid[i] = 0; m_max[i] = 0; m_key[i] = 0; m_upd[i] = 0;
  endtask

  task automatic model_edge(input int i, input bit v, input bit c, input int d, input int k, input bit en);
    int s;
    if (c) begin
      model_clear(i);
    end else if (v) begin
      if (hlen[i] >= HMAX) model_clear(i);
      hist[i][hlen[i]] = d & mask[i];
      hlen[i]++;
      m_upd[i] = 0;
      if (hlen[i] >= win[i]) begin
        s = model_sum(i);
        if (en && (m_valid[i] == 0 || s > m_max[i] || (tie[i] == 1 && s == m_max[i]))) begin
          m_valid[i] = 1; m_max[i] = s; m_key[i] = k; m_upd[i] = 1;
        end
      end
    end else begin
      m_upd[i] = 0;
    end
  endtask

  task automatic check_outputs();
    check("a.window_full", a_full,   (hlen[0] >= win[0]) ? 1 : 0);
    check("a.cur_sum",     a_sum,    model_sum(0));
    check("a.max_valid",   a_mvalid, m_valid[0]);
    check("a.max_sum",     a_max,    m_max[0]);
    check("a.max_key",     a_key,    m_key[0]);
    check("a.max_update",  a_upd,    m_upd[0]);
    check("b.window_full", b_full,   (hlen[1] >= win[1]) ? 1 : 0);
    check("b.cur_sum",     b_sum,    model_sum(1));
    check("b.max_valid",   b_mvalid, m_valid[1]);
    check("b.max_sum",     b_max,    m_max[1]);
    check("b.max_key",     b_key,    m_key[1]);
    check("b.max_update",  b_upd,    m_upd[1]);
  endtask

  task automatic cycle(input bit v, input bit c, input int d, input int k, input bit en);
    @(negedge clk);
    in_valid = v; clear = c; data = 4'(d); key = 16'(k); enable = en;
    @(posedge clk);
    model_edge(0, v, c, d, k, en);
    model_edge(1, v, c, d, k, en);
    #1;
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".a_full"}, a_full, 0);   check({tag, ".a_sum"}, a_sum, 0);
    check({tag, ".a_valid"}, a_mvalid, 0); check({tag, ".a_max"}, a_max, 0);
    check({tag, ".a_key"}, a_key, 0);     check({tag, ".a_upd"}, a_upd, 0);
    check({tag, ".b_sum"}, b_sum, 0);     check({tag, ".b_max"}, b_max, 0);
  endtask

  task automatic random_cycles(input int n);
    for (int j = 0; j < n; j++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 15), $urandom_range(0, 65535), $urandom_range(0, 4) != 0);
    end
  endtask

  int gate_vals [8] = '{2, 2, 2, 1, 1, 1, 1, 0};

  initial begin
    model_clear(0);
    model_clear(1);
    #12;
    check_all_zero("reset_state");
    @(negedge clk);
    reset = 1'b1;

    // Fill with 3s, keys 1..8: no update before the 8th sample.
    for (int k = 1; k <= 8; k++) begin
      cycle(1, 0, 3, k, 1);
      if (k < 8) check("fill.no_early_upd", a_upd, 0);
    end
    check("fill.cur_sum", a_sum, 24);
    check("fill.max_sum", a_max, 24);
    check("fill.max_key", a_key, 8);
    check("fill.full", a_full, 1);

    // Slide zeros through, then 1 and 2.
    for (int j = 1; j <= 8; j++) begin
      cycle(1, 0, 0, 8 + j, 1);
      check("slide.cur_sum", a_sum, 24 - 3 * j);
    end
    cycle(1, 0, 1, 17, 1);
    cycle(1, 0, 2, 18, 1);
    check("slide.final_sum", a_sum, 3);
    check("slide.max_kept", a_key, 8);

    // Ties: sixteen 1s keep the earlier key on dut_a.
    cycle(0, 1, 0, 0, 0);
    for (int k = 1; k <= 16; k++) cycle(1, 0, 1, k, 1);
    check("tie.earlier_key", a_key, 8);
    check("tie.b_key", b_key, 16);

    // Idle cycles freeze state; enable=0 blocks a larger window.
    for (int j = 0; j < 4; j++) cycle(0, 0, $urandom_range(0, 15), $urandom_range(0, 65535), 1);
    cycle(0, 1, 0, 0, 0);
    for (int j = 0; j < 8; j++) cycle(1, 0, gate_vals[j], 100 + j, 1);
    check("gate.max10", a_max, 10);
    cycle(1, 0, 3, 200, 0);
    check("gate.sum11", a_sum, 11);
    check("gate.max_held", a_max, 10);
    check("gate.no_upd", a_upd, 0);

    // Clear together with in_valid drops the sample; refill needs eight fresh samples.
    cycle(1, 1, 3, 300, 1);
    check("clear.sum", a_sum, 0);
    check("clear.valid", a_mvalid, 0);
    for (int j = 0; j < 7; j++) cycle(1, 0, 1, 301 + j, 1);
    check("clear.not_full", a_full, 0);
    cycle(1, 0, 1, 308, 1);
    check("clear.full", a_full, 1);

    // Wide instance: sixteen 15s reach 240 without overflow.
    cycle(0, 1, 0, 0, 0);
    for (int j = 0; j < 16; j++) cycle(1, 0, 15, 400 + j, 1);
    check("wide.cur_sum", b_sum, 240);
    check("wide.max_sum", b_max, 240);

    random_cycles(600);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_clear(0);
    model_clear(1);
    @(negedge clk);
    reset = 1'b1;

    random_cycles(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
